// File: rtl/weight_enum_pkg.sv
// weight_enum_pkg
// Shared definitions for the weight_enum block: FSM state encoding,
// weight-port width helper and the first/last word helpers.
// Helpers return 16-bit words (the largest legal N); callers cast the
// result down to their own width.
package weight_enum_pkg;

  // FSM state encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Width of a field able to hold any weight 0..n
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Smallest word with k ones: k ones packed at the bottom
  function automatic logic [15:0] first_word(input int k);
    return 16'((32'd1 << k) - 32'd1);
  endfunction

  // Largest n-bit word with k ones: k ones packed at the top
  function automatic logic [15:0] last_word(input int k, input int n);
    return 16'(((32'd1 << k) - 32'd1) << (n - k));
  endfunction

endpackage

// File: rtl/weight_enum_next_same_weight.sv
// next_same_weight
// Combinational Gosper step: returns the next larger N-bit word with the
// same number of ones as v.
// Ports:
//   v   : current word (must be nonzero for a meaningful result)
//   nxt : next word of the same weight
module next_same_weight
  import weight_enum_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] v,
  output logic [N-1:0] nxt
);

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  logic [N:0] vx;
  logic [N:0] c;
  logic [N:0] r;
  logic [N:0] tail;
  logic [4:0] tz;

  // One extra bit keeps the carry out of the top run of ones, otherwise
  // the xor below would lose the length of the run that moved.
  assign vx = {1'b0, v};

  // Scanning downward means the lowest set bit is the last one written,
  // so tz ends up as the trailing-zero count.
  always_comb begin
    tz = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) tz = 5'(i);
    end
  end

  // Dividing by the lowest set bit is a right shift by its position.
  assign c    = vx & (~vx + ONE);
  assign r    = vx + c;
  assign tail = ((vx ^ r) >> 2) >> tz;
  assign nxt  = N'(r | tail);

endmodule

// File: rtl/weight_enum.sv
// weight_enum
// Enumerates every N-bit word containing exactly k ones, in ascending
// order, one word per cycle over a valid/ready stream.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start, k    : request enumeration of weight k (accepted only in IDLE)
//   out_ready   : downstream ready
//   out_valid   : out_word holds a valid combination
//   out_word    : current combination
//   out_last    : out_word is the final combination of this run
//   busy        : enumeration in progress
//   err         : one-cycle pulse after a start with k > N
//   chk_err     : sticky self-check failure (only with WEIGHT_ENUM_SELF_CHECK_EN)
// Optional macro: WEIGHT_ENUM_SELF_CHECK_EN adds popcount/ordering checking
// of every handshaken word.
module weight_enum
  import weight_enum_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = calc_cw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] k,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_word,
  output logic          out_last,
  output logic          busy,
`ifdef WEIGHT_ENUM_SELF_CHECK_EN
  output logic          chk_err,
`endif
  output logic          err
);

  localparam logic [CW-1:0] MAXK = CW'(N);

  logic [0:0]    state;
  logic [N-1:0]  word;
  logic [CW-1:0] k_lat;
  logic          err_q;
  logic [N-1:0]  first_w;
  logic [N-1:0]  last_w;
  logic [N-1:0]  nxt;
  logic          is_last;
  logic          hs;

  assign first_w = N'(first_word(int'(k)));
  assign last_w  = N'(last_word(int'(k_lat), N));
  assign is_last = (state == EMIT) && (word == last_w);
  assign hs      = (state == EMIT) && out_ready;

  next_same_weight #(.N(N)) u_next (
    .v   (word),
    .nxt (nxt)
  );

  // Main FSM. The word register is cleared on leaving EMIT so out_word
  // reads zero whenever nothing is being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      k_lat <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k > MAXK) begin
              err_q <= 1'b1;
            end else begin
              word  <= first_w;
              k_lat <= k;
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (hs) begin
            if (is_last) begin
              word  <= '0;
              state <= IDLE;
            end else begin
              word <= nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_word  = word;
  assign out_last  = is_last;
  assign err       = err_q;

`ifdef WEIGHT_ENUM_SELF_CHECK_EN
  logic [CW-1:0] pop;
  logic [N-1:0]  prev_word;
  logic          have_prev;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(word[i]);
    end
  end

  // Every handshaken word must carry k ones and be strictly above the
  // previous word of the same run; any violation latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err   <= 1'b0;
      prev_word <= '0;
      have_prev <= 1'b0;
    end else begin
      if ((state == IDLE) && start) have_prev <= 1'b0;
      if (hs) begin
        if ((pop != k_lat) || (have_prev && (word <= prev_word))) chk_err <= 1'b1;
        prev_word <= word;
        have_prev <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_weight_enum.sv
// tb_weight_enum
// Scoreboard bench for weight_enum with N=4: stimulus pushes the
// hand-computed word sequence, a negedge monitor pops and compares on
// every handshake and also watches stall stability and stray outputs.
module tb_weight_enum;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] k;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_word;
  logic       out_last;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] word;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Hand-computed combinations for N=4, indexed by weight
  logic [3:0] tbl [5][6] = '{
    '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
    '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0},
    '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC},
    '{4'h7, 4'hB, 4'hD, 4'hE, 4'h0, 4'h0},
    '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}
  };
  int cnt [5] = '{1, 4, 6, 4, 1};

  logic       errAllowed = 1'b0;
  logic       stallPrev  = 1'b0;
  logic [3:0] heldWord   = '0;
  logic       heldLast   = 1'b0;

  weight_enum #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushRun(input int kv);
    for (int i = 0; i < cnt[kv]; i++) begin
      exp_q.push_back('{word: tbl[kv][i], last: (i == cnt[kv] - 1)});
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] kv);
    start = 1'b1;
    k     = kv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitEmpty(input int maxc, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < maxc) begin
      @(negedge clk);
      #1;
      used++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_last"}, out_last, 1'b0);
  endtask

  // Monitor: compares each handshaken word with the scoreboard head and
  // checks that stalled outputs hold still.
  always @(negedge clk) begin
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (!errAllowed) checkOutput("err_quiet", err, 1'b0);
      if (out_valid && stallPrev) begin
        checkOutput("stall_word", out_word, heldWord);
        checkOutput("stall_last", out_last, heldLast);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_valid", out_valid, 1'b0);
        end else if (out_ready) begin
          mon_e = exp_q.pop_front();
          checkOutput("word", out_word, mon_e.word);
          checkOutput("last", out_last, mon_e.last);
        end
      end
      stallPrev = out_valid && !out_ready;
      heldWord  = out_word;
      heldLast  = out_last;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int used;
    int cyc;

    rst       = 1'b1;
    start     = 1'b0;
    k         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_word", out_word, 4'h0);
    checkOutput("rst_last", out_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // k=2 at full throughput
    pushRun(2);
    applyStimulus(3'd2);
    checkOutput("k2_latency_valid", out_valid, 1'b1);
    checkOutput("k2_first_word", out_word, 4'h3);
    waitEmpty(20, used);
    checkOutput("k2_cycles", used, 6);
    @(posedge clk);
    #1;
    checkIdle("k2_end");

    // k=0 then k=4 started in the first IDLE cycle
    pushRun(0);
    applyStimulus(3'd0);
    waitEmpty(10, used);
    checkOutput("k0_cycles", used, 1);
    @(posedge clk);
    #1;
    checkIdle("k0_end");
    pushRun(4);
    applyStimulus(3'd4);
    checkOutput("k4_word", out_word, 4'hF);
    waitEmpty(10, used);
    checkOutput("k4_cycles", used, 1);
    @(posedge clk);
    #1;
    checkIdle("k4_end");

    // k=5 is out of range
    errAllowed = 1'b1;
    start = 1'b1;
    k     = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("k5_err_high", err, 1'b1);
    checkOutput("k5_valid", out_valid, 1'b0);
    checkOutput("k5_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("k5_err_low", err, 1'b0);
    checkOutput("k5_busy2", busy, 1'b0);
    errAllowed = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // k=1 with ready pattern 1,0,0,1,0,0,...
    pushRun(1);
    applyStimulus(3'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      out_ready = ((cyc % 3) == 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b1;
    checkOutput("k1_drain", exp_q.size(), 0);
    exp_q.delete();
    checkIdle("k1_end");

    // k=3 with start pulsed mid-run and during the final handshake
    pushRun(3);
    applyStimulus(3'd3);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      start = (cyc == 1) || (exp_q.size() == 1);
      k     = 3'd1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("k3_drain", exp_q.size(), 0);
    exp_q.delete();
    checkIdle("k3_end");
    repeat (3) @(posedge clk);
    #1;

    // k=2 aborted by reset after the second handshake, then restarted
    pushRun(2);
    applyStimulus(3'd2);
    cyc = 0;
    while (exp_q.size() > 4 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("abort_progress", exp_q.size(), 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdle("abort");
    checkOutput("abort_word", out_word, 4'h0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    pushRun(2);
    applyStimulus(3'd2);
    checkOutput("restart_word", out_word, 4'h3);
    waitEmpty(20, used);
    checkOutput("restart_cycles", used, 6);
    @(posedge clk);
    #1;
    checkIdle("restart_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
